// File: rtl/ahb_burst_addr_gen_if.sv
// rtl/ahb_burst_addr_gen_if.sv - request and AHB address-phase signal bundle for the burst address generator
interface ahb_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_burst;
    logic [2:0]            req_size;
    logic [7:0]            req_len;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic                  HREADY;
    logic                  HRESP;
    logic                  req_err;
    logic                  done;

    // Address generator side: accepts requests, drives the AHB address phase
    modport master (
        input  req_valid, req_addr, req_burst, req_size, req_len, req_write,
        input  HREADY, HRESP,
        output req_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE, req_err, done
    );

    // Requester / slave side: issues requests, returns HREADY/HRESP
    modport slave (
        output req_valid, req_addr, req_burst, req_size, req_len, req_write,
        output HREADY, HRESP,
        input  req_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE, req_err, done
    );
endinterface

// File: rtl/ahb_burst_addr_gen.sv
// rtl/ahb_burst_addr_gen.sv - AHB master address-phase sequencer for all eight burst types
module ahb_burst_addr_gen #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INCR_MAX_LEN = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_burst_addr_gen_if.master bus
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    // Boundary check runs wider than HADDR so a carry out of the top never hides a crossing
    localparam int EXT_W    = ADDR_WIDTH + 16;

    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;
    localparam logic [2:0] BURST_WRAP4  = 3'd2;
    localparam logic [2:0] BURST_INCR4  = 3'd3;
    localparam logic [2:0] BURST_WRAP8  = 3'd4;
    localparam logic [2:0] BURST_INCR8  = 3'd5;
    localparam logic [2:0] BURST_WRAP16 = 3'd6;
    localparam logic [2:0] BURST_INCR16 = 3'd7;

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [2:0]            r_hburst;
    logic [2:0]            r_hsize;
    logic                  r_hwrite;
    logic [7:0]            r_beat;
    logic [7:0]            r_last_beat;
    logic [ADDR_WIDTH-1:0] r_bytes;
    logic [ADDR_WIDTH-1:0] r_mask;
    logic                  r_done;
    logic                  r_req_err;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_is_wrap;
    logic [7:0]            w_len;
    logic [15:0]           w_span;
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [EXT_W-1:0]      w_addr_ext;
    logic [EXT_W-1:0]      w_end_ext;
    logic                  w_size_bad;
    logic                  w_misaligned;
    logic                  w_len_bad;
    logic                  w_cross;
    logic                  w_wrap_big;
    logic                  w_req_ok;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [1:0]            w_htrans;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_done_nxt;
    logic                  w_err_nxt;

    assign w_req_ready = (r_state == S_IDLE) && HRESETn;
    assign w_accept    = bus.req_valid && w_req_ready;

    // Decode the incoming request: beat count, byte span and wrap/increment kind
    always_comb begin
        w_is_wrap = 1'b0;
        w_len     = 8'd1;
        case (bus.req_burst)
            BURST_SINGLE: w_len = 8'd1;
            BURST_INCR:   w_len = bus.req_len;
            BURST_WRAP4:  begin w_len = 8'd4;  w_is_wrap = 1'b1; end
            BURST_INCR4:  w_len = 8'd4;
            BURST_WRAP8:  begin w_len = 8'd8;  w_is_wrap = 1'b1; end
            BURST_INCR8:  w_len = 8'd8;
            BURST_WRAP16: begin w_len = 8'd16; w_is_wrap = 1'b1; end
            BURST_INCR16: w_len = 8'd16;
            default:      w_len = 8'd1;
        endcase
    end

    assign w_span     = {8'd0, w_len} << bus.req_size;
    assign w_bytes    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << bus.req_size;
    // Incrementing bursts use an all-ones mask so the wrap formula degenerates to addr+B
    assign w_mask     = w_is_wrap ? ADDR_WIDTH'(w_span - 16'd1) : {ADDR_WIDTH{1'b1}};
    assign w_addr_ext = {16'd0, bus.req_addr};
    assign w_end_ext  = w_addr_ext + {{ADDR_WIDTH{1'b0}}, w_span} - {{(EXT_W-1){1'b0}}, 1'b1};

    assign w_size_bad   = bus.req_size > 3'(MAX_SIZE);
    assign w_misaligned = |(bus.req_addr & (w_bytes - {{(ADDR_WIDTH-1){1'b0}}, 1'b1}));
    assign w_len_bad    = (bus.req_burst == BURST_INCR) &&
                          ((bus.req_len == 8'd0) || (bus.req_len > 8'(INCR_MAX_LEN)));
    assign w_cross      = !w_is_wrap && ((w_end_ext >> 10) != (w_addr_ext >> 10));
    assign w_wrap_big   = w_is_wrap && (w_span > 16'd1024);
    assign w_req_ok     = !(w_size_bad || w_misaligned || w_len_bad || w_cross || w_wrap_big);

    // Next beat address: only the bits under the mask move, the rest stay at the wrap base
    assign w_addr_inc = r_haddr + r_bytes;
    assign w_addr_nxt = (r_haddr & ~r_mask) | (w_addr_inc & r_mask);

    // Next-state and pulse decode; error responses take priority over beat progress
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_htrans    = TRANS_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_ok) begin
                        w_state_nxt = S_ADDR;
                        w_load      = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                w_htrans = (r_beat == 8'd0) ? TRANS_NONSEQ : TRANS_SEQ;
                if (bus.HRESP) begin
                    if (bus.HREADY) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end else if (bus.HREADY) begin
                    if (r_beat == r_last_beat) begin
                        w_state_nxt = S_LAST;
                    end else begin
                        w_advance   = 1'b1;
                    end
                end
            end
            S_LAST: begin
                if (bus.HRESP) begin
                    if (bus.HREADY) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end else if (bus.HREADY) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_ERR: begin
                if (bus.HREADY) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and the one-cycle done/req_err pulses
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_req_err <= w_err_nxt;
        end
    end

    // Burst context: captured on accept, address and beat stepped on each completed beat
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_haddr     <= '0;
            r_hburst    <= 3'd0;
            r_hsize     <= 3'd0;
            r_hwrite    <= 1'b0;
            r_beat      <= 8'd0;
            r_last_beat <= 8'd0;
            r_bytes     <= '0;
            r_mask      <= '0;
        end else if (w_load) begin
            r_haddr     <= bus.req_addr;
            r_hburst    <= bus.req_burst;
            r_hsize     <= bus.req_size;
            r_hwrite    <= bus.req_write;
            r_beat      <= 8'd0;
            r_last_beat <= w_len - 8'd1;
            r_bytes     <= w_bytes;
            r_mask      <= w_mask;
        end else if (w_advance) begin
            r_haddr     <= w_addr_nxt;
            r_beat      <= r_beat + 8'd1;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.HADDR     = r_haddr;
    assign bus.HTRANS    = w_htrans;
    assign bus.HBURST    = r_hburst;
    assign bus.HSIZE     = r_hsize;
    assign bus.HWRITE    = r_hwrite;
    assign bus.req_err   = r_req_err;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// tb/tb_ahb_burst_addr_gen.sv - directed vector bench for ahb_burst_addr_gen
module tb_ahb_burst_addr_gen;

    logic clk;
    logic rstn;

    int n_checks;
    int n_errors;

    ahb_burst_addr_gen_if #(.ADDR_WIDTH(32)) bus ();

    ahb_burst_addr_gen #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .INCR_MAX_LEN (16)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      addr;
        logic [2:0]       burst;
        logic [2:0]       size;
        logic [7:0]       len;
        logic             wr;
        logic             rej;
        logic [4:0]       nbeats;
        logic [7:0][11:0] exp_a;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] burst,
                                input logic [2:0] size, input logic [7:0] len,
                                input logic wr, input logic rej, input logic [4:0] nbeats,
                                input logic [95:0] seq);
        vec_t v;
        v.addr   = addr;
        v.burst  = burst;
        v.size   = size;
        v.len    = len;
        v.wr     = wr;
        v.rej    = rej;
        v.nbeats = nbeats;
        v.exp_a  = seq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [2:0] burst,
                             input logic [2:0] size, input logic [7:0] len, input logic wr);
        bus.req_addr  = addr;
        bus.req_burst = burst;
        bus.req_size  = size;
        bus.req_len   = len;
        bus.req_write = wr;
        bus.req_valid = 1'b1;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        drive_req(v.addr, v.burst, v.size, v.len, v.wr);
        if (v.rej) begin
            @(negedge clk);
            chk($sformatf("v%0d rej req_err", idx), 32'(bus.req_err), 32'd1);
            chk($sformatf("v%0d rej htrans", idx), 32'(bus.HTRANS), 32'd0);
            chk($sformatf("v%0d rej ready", idx), 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d rej pulse end", idx), 32'(bus.req_err), 32'd0);
            chk($sformatf("v%0d rej htrans2", idx), 32'(bus.HTRANS), 32'd0);
        end else begin
            for (int i = 0; i < int'(v.nbeats); i++) begin
                @(negedge clk);
                chk($sformatf("v%0d b%0d htrans", idx, i), 32'(bus.HTRANS), (i == 0) ? 32'd2 : 32'd3);
                if (i < 8)
                    chk($sformatf("v%0d b%0d haddr", idx, i), bus.HADDR, {20'd0, v.exp_a[7-i]});
                if (i == 0) begin
                    chk($sformatf("v%0d hburst", idx), 32'(bus.HBURST), 32'(v.burst));
                    chk($sformatf("v%0d hsize", idx), 32'(bus.HSIZE), 32'(v.size));
                    chk($sformatf("v%0d hwrite", idx), 32'(bus.HWRITE), 32'(v.wr));
                    chk($sformatf("v%0d busy ready", idx), 32'(bus.req_ready), 32'd0);
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d last htrans", idx), 32'(bus.HTRANS), 32'd0);
            chk($sformatf("v%0d last done", idx), 32'(bus.done), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d done", idx), 32'(bus.done), 32'd1);
            chk($sformatf("v%0d no err", idx), 32'(bus.req_err), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = mk(32'h100, 3'd3, 3'd2, 8'd0,  1'b1, 1'b0, 5'd4,
                      {12'h100, 12'h104, 12'h108, 12'h10C, 48'h0});
        vecs[1]  = mk(32'h038, 3'd2, 3'd2, 8'd0,  1'b0, 1'b0, 5'd4,
                      {12'h038, 12'h03C, 12'h030, 12'h034, 48'h0});
        vecs[2]  = mk(32'h00E, 3'd4, 3'd1, 8'd0,  1'b1, 1'b0, 5'd8,
                      {12'h00E, 12'h000, 12'h002, 12'h004, 12'h006, 12'h008, 12'h00A, 12'h00C});
        vecs[3]  = mk(32'h040, 3'd0, 3'd2, 8'd0,  1'b1, 1'b0, 5'd1,
                      {12'h040, 84'h0});
        vecs[4]  = mk(32'h3FB, 3'd1, 3'd0, 8'd5,  1'b0, 1'b0, 5'd5,
                      {12'h3FB, 12'h3FC, 12'h3FD, 12'h3FE, 12'h3FF, 36'h0});
        vecs[5]  = mk(32'h3F0, 3'd5, 3'd2, 8'd0,  1'b0, 1'b1, 5'd0, 96'h0);
        vecs[6]  = mk(32'h102, 3'd3, 3'd2, 8'd0,  1'b0, 1'b1, 5'd0, 96'h0);
        vecs[7]  = mk(32'h200, 3'd1, 3'd0, 8'd0,  1'b0, 1'b1, 5'd0, 96'h0);
        vecs[8]  = mk(32'h200, 3'd0, 3'd3, 8'd0,  1'b0, 1'b1, 5'd0, 96'h0);
        vecs[9]  = mk(32'h200, 3'd1, 3'd0, 8'd17, 1'b0, 1'b1, 5'd0, 96'h0);
        vecs[10] = mk(32'h3C4, 3'd6, 3'd2, 8'd0,  1'b1, 1'b0, 5'd16,
                      {12'h3C4, 12'h3C8, 12'h3CC, 12'h3D0, 12'h3D4, 12'h3D8, 12'h3DC, 12'h3E0});
        vecs[11] = mk(32'h3C0, 3'd7, 3'd2, 8'd0,  1'b0, 1'b0, 5'd16,
                      {12'h3C0, 12'h3C4, 12'h3C8, 12'h3CC, 12'h3D0, 12'h3D4, 12'h3D8, 12'h3DC});
        vecs[12] = mk(32'h3F8, 3'd2, 3'd2, 8'd0,  1'b1, 1'b0, 5'd4,
                      {12'h3F8, 12'h3FC, 12'h3F0, 12'h3F4, 48'h0});
        vecs[13] = mk(32'h000, 3'd1, 3'd0, 8'd16, 1'b0, 1'b0, 5'd16,
                      {12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007});

        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_burst = 3'd0;
        bus.req_size  = 3'd0;
        bus.req_len   = 8'd0;
        bus.req_write = 1'b0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst haddr", bus.HADDR, 32'd0);
        chk("rst hburst", 32'(bus.HBURST), 32'd0);
        chk("rst hsize", 32'(bus.HSIZE), 32'd0);
        chk("rst hwrite", 32'(bus.HWRITE), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst req_err", 32'(bus.req_err), 32'd0);
        chk("rst ready low", 32'(bus.req_ready), 32'd0);
        rstn = 1'b1;
        #1;
        chk("ready after rst", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // table: consecutive vectors also exercise accept in the done cycle
        for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

        // INCR len 3 with two wait states on beat 1
        @(negedge clk);
        drive_req(32'h200, 3'd1, 3'd0, 8'd3, 1'b0);
        @(negedge clk);
        chk("ws b0 haddr", bus.HADDR, 32'h200);
        chk("ws b0 htrans", 32'(bus.HTRANS), 32'd2);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ws b1 haddr", bus.HADDR, 32'h201);
        bus.HREADY = 1'b0;
        @(negedge clk);
        chk("ws hold1 haddr", bus.HADDR, 32'h201);
        chk("ws hold1 htrans", 32'(bus.HTRANS), 32'd3);
        @(negedge clk);
        chk("ws hold2 haddr", bus.HADDR, 32'h201);
        chk("ws hold2 htrans", 32'(bus.HTRANS), 32'd3);
        bus.HREADY = 1'b1;
        @(negedge clk);
        chk("ws b2 haddr", bus.HADDR, 32'h202);
        chk("ws b2 htrans", 32'(bus.HTRANS), 32'd3);
        @(negedge clk);
        chk("ws last htrans", 32'(bus.HTRANS), 32'd0);
        @(negedge clk);
        chk("ws done", 32'(bus.done), 32'd1);

        // INCR16 with a two-cycle ERROR response on beat 5
        @(negedge clk);
        drive_req(32'h000, 3'd7, 3'd2, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("er b%0d haddr", i), bus.HADDR, 32'(4 * i));
            bus.req_valid = 1'b0;
        end
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        @(negedge clk);
        chk("er1 htrans", 32'(bus.HTRANS), 32'd0);
        chk("er1 req_err", 32'(bus.req_err), 32'd0);
        bus.HREADY = 1'b1;
        @(negedge clk);
        chk("er2 req_err", 32'(bus.req_err), 32'd1);
        chk("er2 done", 32'(bus.done), 32'd0);
        chk("er2 ready", 32'(bus.req_ready), 32'd1);
        bus.HRESP = 1'b0;
        @(negedge clk);
        chk("er3 req_err", 32'(bus.req_err), 32'd0);
        chk("er3 done", 32'(bus.done), 32'd0);

        // HRESP with HREADY high in the same cycle aborts straight to IDLE
        drive_req(32'h040, 3'd0, 3'd2, 8'd0, 1'b0);
        @(negedge clk);
        chk("il htrans", 32'(bus.HTRANS), 32'd2);
        bus.req_valid = 1'b0;
        bus.HRESP     = 1'b1;
        @(negedge clk);
        chk("il req_err", 32'(bus.req_err), 32'd1);
        chk("il htrans idle", 32'(bus.HTRANS), 32'd0);
        bus.HRESP = 1'b0;
        @(negedge clk);
        chk("il pulse end", 32'(bus.req_err), 32'd0);
        chk("il no done", 32'(bus.done), 32'd0);

        // request while busy is dropped, not queued
        drive_req(32'h100, 3'd3, 3'd2, 8'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        drive_req(32'h300, 3'd0, 3'd2, 8'd0, 1'b1);
        @(negedge clk);
        chk("ign haddr", bus.HADDR, 32'h108);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("ign done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("ign not queued", 32'(bus.HTRANS), 32'd0);

        // reset during beat 2 of INCR8, then a clean SINGLE
        drive_req(32'h080, 3'd5, 3'd2, 8'd0, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr b2 haddr", bus.HADDR, 32'h088);
        rstn = 1'b0;
        @(negedge clk);
        chk("mr htrans", 32'(bus.HTRANS), 32'd0);
        chk("mr haddr", bus.HADDR, 32'd0);
        chk("mr hburst", 32'(bus.HBURST), 32'd0);
        chk("mr hwrite", 32'(bus.HWRITE), 32'd0);
        chk("mr done", 32'(bus.done), 32'd0);
        chk("mr req_err", 32'(bus.req_err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mr idle done", 32'(bus.done), 32'd0);
        chk("mr idle err", 32'(bus.req_err), 32'd0);
        drive_req(32'h040, 3'd0, 3'd2, 8'd0, 1'b1);
        @(negedge clk);
        chk("mr s haddr", bus.HADDR, 32'h040);
        chk("mr s htrans", 32'(bus.HTRANS), 32'd2);
        chk("mr s hwrite", 32'(bus.HWRITE), 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mr s last", 32'(bus.HTRANS), 32'd0);
        @(negedge clk);
        chk("mr s done", 32'(bus.done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
